// File: rtl/mrd_bus_master_if.sv
// Request/response handshake and strobed target-bus signals of mrd_bus_master.
// master = bus initiator (the design), slave = request source / target side.
interface mrd_bus_master_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_write;
  logic [6:0] req_adr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_mismatch;
  logic [6:0] adr_out;
  logic [7:0] data_out;
  logic       data_oe;
  logic [7:0] data_in;
  logic       n_cs;
  logic       n_read;
  logic       n_write;

  modport master (
    input  req_valid, req_write, req_adr, req_wdata, data_in,
    output req_ready, rsp_valid, rsp_rdata, rsp_mismatch,
           adr_out, data_out, data_oe, n_cs, n_read, n_write
  );

  modport slave (
    output req_valid, req_write, req_adr, req_wdata, data_in,
    input  req_ready, rsp_valid, rsp_rdata, rsp_mismatch,
           adr_out, data_out, data_oe, n_cs, n_read, n_write
  );
endinterface

// File: rtl/mrd_bus_master.sv
// Single-request initiator for the 7-bit/8-bit strobed target bus, fully registered outputs.
// Optional MRD_BUS_MASTER_RDCHK_EN adds a mid-strobe read sample and a consistency flag.
module mrd_bus_master #(
  parameter int SETUP  = 2,
  parameter int STROBE = 4,
  parameter int HOLD   = 2
) (
  input logic               clk,
  input logic               n_reset,
  mrd_bus_master_if.master  bus
);
  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD} state_t;

  localparam logic [7:0] SETUP_LAST  = 8'(SETUP - 1);
  localparam logic [7:0] STROBE_LAST = 8'(STROBE - 1);
  localparam logic [7:0] HOLD_LAST   = 8'(HOLD - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       wr_q, wr_d;
  logic [7:0] cap_q, cap_d;
  logic       req_ready_q, req_ready_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic [7:0] rsp_rdata_q, rsp_rdata_d;
  logic [6:0] adr_q, adr_d;
  logic [7:0] dout_q, dout_d;
  logic       oe_q, oe_d;
  logic       ncs_q, ncs_d;
  logic       nrd_q, nrd_d;
  logic       nwr_q, nwr_d;
  logic       accept;
  logic       busy;

`ifdef MRD_BUS_MASTER_RDCHK_EN
  localparam logic [7:0] MID_LAST = 8'(STROBE / 2 - 1);
  logic [7:0] mid_q, mid_d;
  logic       mm_q, mm_d;
`endif

  assign accept = bus.req_valid && req_ready_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 8'd1;
    wr_d        = wr_q;
    cap_d       = cap_q;
    adr_d       = adr_q;
    dout_d      = dout_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
`ifdef MRD_BUS_MASTER_RDCHK_EN
    mid_d       = mid_q;
    mm_d        = mm_q;
`endif
    case (state_q)
      S_IDLE: begin
        cnt_d = 8'd0;
        if (accept) begin
          state_d = S_SETUP;
          wr_d    = bus.req_write;
          adr_d   = bus.req_adr;
          if (bus.req_write) dout_d = bus.req_wdata;
        end
      end
      S_SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          state_d = S_STROBE;
          cnt_d   = 8'd0;
        end
      end
      S_STROBE: begin
`ifdef MRD_BUS_MASTER_RDCHK_EN
        if (cnt_q == MID_LAST) mid_d = bus.data_in;
`endif
        // data_in is already registered by the IO cell; take it on the edge that ends the strobe
        if (cnt_q == STROBE_LAST) begin
          state_d = S_HOLD;
          cnt_d   = 8'd0;
          cap_d   = bus.data_in;
        end
      end
      S_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d     = S_IDLE;
          cnt_d       = 8'd0;
          rsp_valid_d = 1'b1;
          if (!wr_q) rsp_rdata_d = cap_q;
`ifdef MRD_BUS_MASTER_RDCHK_EN
          mm_d = !wr_q && (mid_q != cap_q);
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so every pin comes straight from a flop
    busy        = (state_d != S_IDLE);
    req_ready_d = !busy;
    ncs_d       = !busy;
    nrd_d       = !((state_d == S_STROBE) && !wr_d);
    nwr_d       = !((state_d == S_STROBE) && wr_d);
    oe_d        = busy && wr_d;
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 8'd0;
      wr_q        <= 1'b0;
      cap_q       <= 8'd0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 8'd0;
      adr_q       <= 7'd0;
      dout_q      <= 8'd0;
      oe_q        <= 1'b0;
      ncs_q       <= 1'b1;
      nrd_q       <= 1'b1;
      nwr_q       <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_q        <= wr_d;
      cap_q       <= cap_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      adr_q       <= adr_d;
      dout_q      <= dout_d;
      oe_q        <= oe_d;
      ncs_q       <= ncs_d;
      nrd_q       <= nrd_d;
      nwr_q       <= nwr_d;
    end
  end

`ifdef MRD_BUS_MASTER_RDCHK_EN
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      mid_q <= 8'd0;
      mm_q  <= 1'b0;
    end else begin
      mid_q <= mid_d;
      mm_q  <= mm_d;
    end
  end
  assign bus.rsp_mismatch = mm_q;
`else
  assign bus.rsp_mismatch = 1'b0;
`endif

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.adr_out   = adr_q;
  assign bus.data_out  = dout_q;
  assign bus.data_oe   = oe_q;
  assign bus.n_cs      = ncs_q;
  assign bus.n_read    = nrd_q;
  assign bus.n_write   = nwr_q;
endmodule
